// File: rtl/cv32e40p_pkg.sv
// ============================================================================
// Module      : cv32e40p_pkg
// Description : Shared types and constants for the cluster-side p.elw event
//               unit (state enumeration and register offsets).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cv32e40p_pkg;

    // Event-unit FSM states
    typedef enum logic [2:0] {
        ELW_IDLE     = 3'd0,
        ELW_RESP     = 3'd1,
        ELW_WAIT_EVT = 3'd2,
        ELW_SLEEP    = 3'd3,
        ELW_WAKE     = 3'd4
    } elw_eu_state_e;

    // Event-unit register offsets
    localparam logic [1:0] EU_MASK   = 2'd0;
    localparam logic [1:0] EU_BUFFER = 2'd1;
    localparam logic [1:0] EU_WAIT   = 2'd2;
    localparam logic [1:0] EU_CLEAR  = 2'd3;

endpackage

`default_nettype wire

// File: rtl/cv32e40p_elw_event_unit.sv
// ============================================================================
// Module      : cv32e40p_elw_event_unit
// Description : Services p.elw accesses from the core: buffers event lines,
//               answers a blocking WAIT read and gates the core clock while
//               the core sleeps with no wake source pending.
//               Optional macro CV32E40P_ELW_IRQ_WAKE_EN makes any irq_i bit
//               a wake source.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cv32e40p_elw_event_unit
    import cv32e40p_pkg::*;
#(
    parameter int NUM_EVENTS = 8
) (
    input  logic                  clk_ungated_i,
    input  logic                  rst_n,
    input  logic                  core_sleep_i,
    output logic                  pulp_clock_en_o,
    input  logic [NUM_EVENTS-1:0] event_i,
    input  logic                  elw_req_i,
    input  logic                  elw_we_i,
    input  logic [1:0]            elw_offset_i,
    input  logic [31:0]           elw_wdata_i,
    output logic                  elw_gnt_o,
    output logic                  elw_rvalid_o,
    output logic [31:0]           elw_rdata_o,
    input  logic [31:0]           irq_i,
    output logic [31:0]           irq_o,
    input  logic                  debug_req_i,
    output logic                  debug_req_o
);

    elw_eu_state_e         r_state;
    elw_eu_state_e         w_state_nxt;
    logic [NUM_EVENTS-1:0] r_mask;
    logic [NUM_EVENTS-1:0] r_buffer;
    logic [NUM_EVENTS-1:0] r_rdata;
    logic                  r_clk_en;
    logic [NUM_EVENTS-1:0] w_pend;
    logic [NUM_EVENTS-1:0] w_clr;
    logic [NUM_EVENTS-1:0] w_rsp_data;
    logic                  w_mask_we;
    logic                  w_any_pend;
    logic                  w_wake;
    logic                  w_access;
    logic                  w_wdata_unused;

    // Bits of the write data above the event width have no destination
    assign w_wdata_unused = |(elw_wdata_i >> NUM_EVENTS);

    // Events arriving this cycle already count as pending
    assign w_pend     = (r_buffer | event_i) & r_mask;
    assign w_any_pend = |w_pend;
    assign w_access   = (r_state == ELW_IDLE) && elw_req_i;

`ifdef CV32E40P_ELW_IRQ_WAKE_EN
    assign w_wake = w_any_pend | debug_req_i | (|irq_i);
`else
    assign w_wake = w_any_pend | debug_req_i;
`endif

    // State register
    always_ff @(posedge clk_ungated_i or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ELW_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ELW_IDLE: begin
                if (elw_req_i) begin
                    if (!elw_we_i && (elw_offset_i == EU_WAIT) && !w_any_pend) begin
                        w_state_nxt = ELW_WAIT_EVT;
                    end else begin
                        w_state_nxt = ELW_RESP;
                    end
                end
            end
            ELW_RESP: w_state_nxt = ELW_IDLE;
            ELW_WAIT_EVT: begin
                if (w_any_pend) begin
                    w_state_nxt = ELW_RESP;
                end else if (core_sleep_i && !w_wake) begin
                    w_state_nxt = ELW_SLEEP;
                end
            end
            // Losing core_sleep_i while asleep is illegal; recover through WAKE
            ELW_SLEEP: begin
                if (w_wake || !core_sleep_i) begin
                    w_state_nxt = ELW_WAKE;
                end
            end
            // A non-event wake leaves the WAIT outstanding
            ELW_WAKE: w_state_nxt = w_any_pend ? ELW_RESP : ELW_WAIT_EVT;
            default:  w_state_nxt = ELW_IDLE;
        endcase
    end

    // Register access decode and response data selection
    always_comb begin
        w_clr      = '0;
        w_rsp_data = '0;
        w_mask_we  = 1'b0;
        if (w_access) begin
            if (elw_we_i) begin
                if (elw_offset_i == EU_MASK) begin
                    w_mask_we = 1'b1;
                end
                if (elw_offset_i == EU_CLEAR) begin
                    w_clr = elw_wdata_i[NUM_EVENTS-1:0];
                end
            end else begin
                case (elw_offset_i)
                    EU_MASK:   w_rsp_data = r_mask;
                    EU_BUFFER: w_rsp_data = r_buffer;
                    EU_WAIT: begin
                        // Empty when the WAIT blocks, so nothing is consumed
                        w_rsp_data = w_pend;
                        w_clr      = w_pend;
                    end
                    default:   w_rsp_data = '0;
                endcase
            end
        end else if (w_state_nxt == ELW_RESP) begin
            // Blocked WAIT completing from WAIT_EVT or WAKE
            w_rsp_data = w_pend;
            w_clr      = w_pend;
        end
    end

    // Mask, sticky event buffer (set beats clear) and response data
    always_ff @(posedge clk_ungated_i or negedge rst_n) begin
        if (!rst_n) begin
            r_mask   <= '0;
            r_buffer <= '0;
            r_rdata  <= '0;
        end else begin
            if (w_mask_we) begin
                r_mask <= elw_wdata_i[NUM_EVENTS-1:0];
            end
            r_buffer <= (r_buffer & ~w_clr) | event_i;
            r_rdata  <= (w_state_nxt == ELW_RESP) ? w_rsp_data : '0;
        end
    end

    // Clock enable registered from the next state so it drops on SLEEP entry
    always_ff @(posedge clk_ungated_i or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_en <= 1'b1;
        end else begin
            r_clk_en <= (w_state_nxt != ELW_SLEEP);
        end
    end

    // Output decode and sleep gating of interrupt/debug lines
    always_comb begin
        elw_gnt_o                    = (r_state == ELW_IDLE) || (r_state == ELW_SLEEP);
        elw_rvalid_o                 = (r_state == ELW_RESP);
        elw_rdata_o                  = '0;
        elw_rdata_o[NUM_EVENTS-1:0]  = r_rdata;
        pulp_clock_en_o              = r_clk_en;
        irq_o                        = (r_state == ELW_SLEEP) ? 32'd0 : irq_i;
        debug_req_o                  = (r_state == ELW_SLEEP) ? 1'b0 : debug_req_i;
    end

endmodule

`default_nettype wire

// File: tb/tb_cv32e40p_elw_event_unit.sv
// ============================================================================
// Module      : tb_cv32e40p_elw_event_unit
// Description : Randomized self-checking bench for the p.elw event unit with
//               a transaction-level model of mask and event buffer.
//               Honours CV32E40P_ELW_IRQ_WAKE_EN for the irq wake scenario.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cv32e40p_elw_event_unit;

    localparam int         NEV     = 8;
    localparam logic [1:0] O_MASK  = 2'd0;
    localparam logic [1:0] O_BUF   = 2'd1;
    localparam logic [1:0] O_WAIT  = 2'd2;
    localparam logic [1:0] O_CLEAR = 2'd3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            core_sleep;
    logic            clk_en;
    logic [NEV-1:0]  event_i;
    logic            req, we;
    logic [1:0]      off;
    logic [31:0]     wdata;
    logic            gnt, rvalid;
    logic [31:0]     rdata;
    logic [31:0]     irq_in, irq_out;
    logic            dbg_in, dbg_out;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state
    logic [NEV-1:0]  m_mask;
    logic [NEV-1:0]  m_buf;

    always #5 clk = ~clk;

    cv32e40p_elw_event_unit #(.NUM_EVENTS(NEV)) dut (
        .clk_ungated_i   (clk),
        .rst_n           (rst_n),
        .core_sleep_i    (core_sleep),
        .pulp_clock_en_o (clk_en),
        .event_i         (event_i),
        .elw_req_i       (req),
        .elw_we_i        (we),
        .elw_offset_i    (off),
        .elw_wdata_i     (wdata),
        .elw_gnt_o       (gnt),
        .elw_rvalid_o    (rvalid),
        .elw_rdata_o     (rdata),
        .irq_i           (irq_in),
        .irq_o           (irq_out),
        .debug_req_i     (dbg_in),
        .debug_req_o     (dbg_out)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; the event buffer keeps what arrived, minus what was consumed
    task automatic next_cycle(input logic [NEV-1:0] ev, input logic [NEV-1:0] clr);
        @(posedge clk);
        #1;
        m_buf = (m_buf & ~clr) | ev;
    endtask

    function automatic logic [NEV-1:0] rand_ev();
        return ($urandom_range(0, 3) == 0) ? NEV'($urandom) : '0;
    endfunction

    function automatic logic [NEV-1:0] pick_masked_bit();
        int b;
        do b = $urandom_range(0, NEV-1); while (!m_mask[b]);
        return NEV'(1) << b;
    endfunction

    // Single register access from IDLE (not a WAIT read)
    task automatic reg_access(input logic w, input logic [1:0] o, input logic [31:0] d,
                              input logic [NEV-1:0] ev);
        logic [31:0]    exp;
        logic [NEV-1:0] clr, ev2;
        exp = '0; clr = '0;
        req = 1'b1; we = w; off = o; wdata = d; event_i = ev;
        @(negedge clk);
        check_eq("acc_gnt", {31'd0, gnt}, 32'd1);
        if (w) begin
            if (o == O_CLEAR) clr = d[NEV-1:0];
        end else begin
            if (o == O_MASK) exp = {24'd0, m_mask};
            if (o == O_BUF)  exp = {24'd0, m_buf};
        end
        next_cycle(ev, clr);
        if (w && o == O_MASK) m_mask = d[NEV-1:0];
        req = 1'b0; we = 1'b0;
        ev2 = rand_ev();
        event_i = ev2;
        @(negedge clk);
        check_eq("acc_rvalid", {31'd0, rvalid}, 32'd1);
        check_eq("acc_rdata", rdata, exp);
        check_eq("acc_gnt_resp", {31'd0, gnt}, 32'd0);
        next_cycle(ev2, '0);
        event_i = '0;
    endtask

    task automatic idle_cycle();
        logic [NEV-1:0] ev;
        ev = rand_ev();
        event_i = ev; irq_in = $urandom; dbg_in = 1'($urandom);
        @(negedge clk);
        check_eq("idle_gnt", {31'd0, gnt}, 32'd1);
        check_eq("idle_rvalid", {31'd0, rvalid}, 32'd0);
        check_eq("idle_clken", {31'd0, clk_en}, 32'd1);
        check_eq("idle_irq", irq_out, irq_in);
        check_eq("idle_dbg", {31'd0, dbg_out}, {31'd0, dbg_in});
        next_cycle(ev, '0);
        event_i = '0; irq_in = '0; dbg_in = 1'b0;
    endtask

    // Core is asleep: a masked event wakes it and completes the WAIT
    task automatic wake_by_event();
        logic [NEV-1:0] ev, exp;
        ev = pick_masked_bit() | (NEV'($urandom) & ~m_mask);
        event_i = ev;
        @(negedge clk);
        check_eq("sleep_clken", {31'd0, clk_en}, 32'd0);
        next_cycle(ev, '0);
        event_i = '0; core_sleep = 1'b0;
        @(negedge clk);
        check_eq("wake_clken", {31'd0, clk_en}, 32'd1);
        check_eq("wake_rvalid", {31'd0, rvalid}, 32'd0);
        check_eq("wake_gnt", {31'd0, gnt}, 32'd0);
        exp = m_buf & m_mask;
        next_cycle('0, exp);
        @(negedge clk);
        check_eq("wresp_rvalid", {31'd0, rvalid}, 32'd1);
        check_eq("wresp_rdata", rdata, {24'd0, exp});
        next_cycle('0, '0);
    endtask

    // WAIT outstanding with the clock running: a masked event completes it
    task automatic finish_from_waitevt();
        logic [NEV-1:0] ev, pend;
        ev = pick_masked_bit();
        event_i = ev;
        @(negedge clk);
        check_eq("wevt_rvalid", {31'd0, rvalid}, 32'd0);
        check_eq("wevt_gnt", {31'd0, gnt}, 32'd0);
        pend = (m_buf | ev) & m_mask;
        next_cycle(ev, pend);
        event_i = '0;
        @(negedge clk);
        check_eq("wevt_resp_rvalid", {31'd0, rvalid}, 32'd1);
        check_eq("wevt_resp_rdata", rdata, {24'd0, pend});
        next_cycle('0, '0);
    endtask

    // Issue WAIT; if it blocks, put the core to sleep and wake by kind
    // (0 event, 1 debug, 2 irq). Returns 1 when the WAIT blocked into SLEEP.
    task automatic wait_txn(input int sleep_len, input int kind, input logic stop_in_sleep,
                            output logic slept);
        logic [NEV-1:0] ev, pend;
        slept = 1'b0;
        ev = rand_ev();
        req = 1'b1; we = 1'b0; off = O_WAIT; event_i = ev; core_sleep = 1'b0;
        @(negedge clk);
        check_eq("wait_gnt", {31'd0, gnt}, 32'd1);
        pend = (m_buf | ev) & m_mask;
        if (pend != '0) begin
            next_cycle(ev, pend);
            req = 1'b0; event_i = '0;
            @(negedge clk);
            check_eq("wait_fast_rvalid", {31'd0, rvalid}, 32'd1);
            check_eq("wait_fast_rdata", rdata, {24'd0, pend});
            next_cycle('0, '0);
            return;
        end
        next_cycle(ev, '0);
        req = 1'b0; core_sleep = 1'b1;
        ev = NEV'($urandom) & ~m_mask;
        event_i = ev;
        @(negedge clk);
        check_eq("wevt_enter_gnt", {31'd0, gnt}, 32'd0);
        check_eq("wevt_enter_clken", {31'd0, clk_en}, 32'd1);
        next_cycle(ev, '0);
        slept = 1'b1;
        for (int i = 0; i < sleep_len; i++) begin
            ev = NEV'($urandom) & ~m_mask;
            event_i = ev;
            @(negedge clk);
            check_eq("sleep_clk_off", {31'd0, clk_en}, 32'd0);
            check_eq("sleep_gnt", {31'd0, gnt}, 32'd1);
            check_eq("sleep_rvalid", {31'd0, rvalid}, 32'd0);
            next_cycle(ev, '0);
        end
        event_i = '0;
        if (stop_in_sleep) return;
        if (kind == 1) begin
            dbg_in = 1'b1;
            @(negedge clk);
            check_eq("dbg_gated", {31'd0, dbg_out}, 32'd0);
            check_eq("dbg_sleep_clken", {31'd0, clk_en}, 32'd0);
            next_cycle('0, '0);
            @(negedge clk);
            check_eq("dbg_wake_out", {31'd0, dbg_out}, 32'd1);
            check_eq("dbg_wake_clken", {31'd0, clk_en}, 32'd1);
            check_eq("dbg_wake_rvalid", {31'd0, rvalid}, 32'd0);
            next_cycle('0, '0);
            core_sleep = 1'b0; dbg_in = 1'b0;
            for (int i = 0; i < 2; i++) begin
                @(negedge clk);
                check_eq("dbg_wevt_gnt", {31'd0, gnt}, 32'd0);
                check_eq("dbg_wevt_rvalid", {31'd0, rvalid}, 32'd0);
                check_eq("dbg_wevt_clken", {31'd0, clk_en}, 32'd1);
                next_cycle('0, '0);
            end
            finish_from_waitevt();
        end else if (kind == 2) begin
            irq_in = 32'h800;
`ifdef CV32E40P_ELW_IRQ_WAKE_EN
            @(negedge clk);
            check_eq("irq_sleep_out", irq_out, 32'd0);
            check_eq("irq_sleep_clken", {31'd0, clk_en}, 32'd0);
            next_cycle('0, '0);
            core_sleep = 1'b0;
            @(negedge clk);
            check_eq("irq_wake_out", irq_out, 32'h800);
            check_eq("irq_wake_clken", {31'd0, clk_en}, 32'd1);
            check_eq("irq_wake_rvalid", {31'd0, rvalid}, 32'd0);
            next_cycle('0, '0);
            irq_in = '0;
            finish_from_waitevt();
`else
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                check_eq("irq_held_out", irq_out, 32'd0);
                check_eq("irq_held_clken", {31'd0, clk_en}, 32'd0);
                check_eq("irq_held_gnt", {31'd0, gnt}, 32'd1);
                next_cycle('0, '0);
            end
            irq_in = '0;
            wake_by_event();
`endif
        end else begin
            wake_by_event();
        end
    endtask

    task automatic ensure_mask();
        if (m_mask == '0) reg_access(1'b1, O_MASK, {$urandom} | 32'h1, '0);
    endtask

    initial begin
        logic slept;
        logic [31:0] d;
        int op;
        rst_n = 1'b0; core_sleep = 1'b0; event_i = '0; req = 1'b0; we = 1'b0;
        off = '0; wdata = '0; irq_in = 32'h1234_5678; dbg_in = 1'b1;
        m_mask = '0; m_buf = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_clken", {31'd0, clk_en}, 32'd1);
        check_eq("rst_rvalid", {31'd0, rvalid}, 32'd0);
        check_eq("rst_rdata", rdata, 32'd0);
        check_eq("rst_gnt", {31'd0, gnt}, 32'd1);
        check_eq("rst_irq", irq_out, 32'h1234_5678);
        check_eq("rst_dbg", {31'd0, dbg_out}, 32'd1);
        irq_in = '0; dbg_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset contents, then MASK write/read-back
        reg_access(1'b0, O_MASK, '0, '0);
        reg_access(1'b0, O_BUF, '0, '0);
        reg_access(1'b1, O_MASK, 32'h5, '0);
        reg_access(1'b0, O_MASK, '0, '0);

        // Unmasked event stays buffered across an event-0 wake
        reg_access(1'b1, O_CLEAR, 32'hFF, '0);
        reg_access(1'b1, O_MASK, 32'h1, '0);
        idle_cycle();
        event_i = 8'h08;
        @(negedge clk);
        next_cycle(8'h08, '0);
        event_i = '0;
        wait_txn(3, 0, 1'b0, slept);
        reg_access(1'b0, O_BUF, '0, '0);

        // Clear and event on the same bit in one cycle: event wins
        reg_access(1'b1, O_CLEAR, 32'h1, 8'h01);
        reg_access(1'b0, O_BUF, '0, '0);
        reg_access(1'b1, O_CLEAR, 32'hFF, '0);

        // Debug and irq wakes
        wait_txn(2, 1, 1'b0, slept);
        reg_access(1'b1, O_CLEAR, 32'hFF, '0);
        wait_txn(2, 2, 1'b0, slept);

        // Randomized mix
        for (int it = 0; it < 60; it++) begin
            op = $urandom_range(0, 6);
            case (op)
                0: reg_access(1'b1, O_MASK, $urandom, rand_ev());
                1: reg_access(1'b0, O_MASK, $urandom, rand_ev());
                2: reg_access(1'b0, O_BUF, $urandom, rand_ev());
                3: reg_access(1'b1, O_CLEAR, $urandom, rand_ev());
                4: repeat ($urandom_range(1, 3)) idle_cycle();
                5: begin
                    ensure_mask();
                    wait_txn($urandom_range(1, 4), $urandom_range(0, 2), 1'b0, slept);
                end
                default: begin
                    d = $urandom;
                    if ($urandom_range(0, 1) == 0) reg_access(1'b1, O_BUF, d, rand_ev());
                    else reg_access(1'b0, O_CLEAR, d, rand_ev());
                end
            endcase
        end

        // Reset while the WAIT is outstanding and the core sleeps
        reg_access(1'b1, O_CLEAR, 32'hFF, '0);
        reg_access(1'b1, O_MASK, 32'h1, '0);
        wait_txn(2, 0, 1'b1, slept);
        check_eq("rstw_slept", {31'd0, slept}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rstw_clken", {31'd0, clk_en}, 32'd1);
        check_eq("rstw_gnt", {31'd0, gnt}, 32'd1);
        check_eq("rstw_rvalid", {31'd0, rvalid}, 32'd0);
        core_sleep = 1'b0;
        m_mask = '0; m_buf = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("rstw_no_resp", {31'd0, rvalid}, 32'd0);
        next_cycle('0, '0);
        reg_access(1'b0, O_MASK, '0, '0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    // Global watchdog so the run always terminates
    initial begin
        #500000;
        n_err++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
